mul_share_arbiter: RTL and testbench

//  Shares one pipelined wide multiplier core (e.g. wallaceAdder_32: In1/In2 -> Out, clk, rstn) among NREQ requesters.

---
 rtl/mul_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one pipelined wide multiplier core among NREQ requesters. One
// operand pair is accepted per cycle by a round-robin arbiter. It is issued
// to the core in the following cycle together with a tag that carries the
// requester id. The tag rides a shift pipe that matches the core latency, so
// the product coming back from the core can be steered to the requester
// that issued it. Results return in issue order and there is no
// backpressure on the response side.
//
// Timing (accept in cycle A, core latency MUL_LAT):
//   A+1               mul_vld / mul_in1 / mul_in2 presented to the core
//   A+1+MUL_LAT       product on mul_out, captured into rsp_data
//   A+2+MUL_LAT       rsp_vld (one-hot), rsp_id, rsp_data visible
//
// Parameters:
//   DATA_W   operand width (product is 2*DATA_W)
//   NREQ     number of requesters (>= 1)
//   MUL_LAT  core latency in cycles (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   req_vld   per-requester request valid
//   req_rdy   per-requester accept (one-hot or zero, combinational)
//   req_in1   operand A, requester i at [i*DATA_W +: DATA_W]
//   req_in2   operand B, same packing
//   mul_vld   operand pair valid to the core
//   mul_in1   operand A to the core (holds when idle)
//   mul_in2   operand B to the core (holds when idle)
//   mul_out   product from the core
//   rsp_vld   one-hot result strobe, one cycle per result
//   rsp_id    requester id of the current result
//   rsp_data  product (holds when rsp_vld is zero)
//   busy      any operation issued, in the core, or being returned
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, arbitration is fixed priority (lowest
//                      index wins) and the round-robin pointer is removed.
//                      High indices may starve in that mode.
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int DATA_W  = 1024,
  parameter int NREQ    = 2,
  parameter int MUL_LAT = 2,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_vld,
  output logic [NREQ-1:0]          req_rdy,
  input  logic [NREQ*DATA_W-1:0]   req_in1,
  input  logic [NREQ*DATA_W-1:0]   req_in2,
  output logic                     mul_vld,
  output logic [DATA_W-1:0]        mul_in1,
  output logic [DATA_W-1:0]        mul_in2,
  input  logic [2*DATA_W-1:0]      mul_out,
  output logic [NREQ-1:0]          rsp_vld,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*DATA_W-1:0]      rsp_data,
  output logic                     busy
);

  function automatic logic [NREQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == id) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic                gnt_any;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_W-1:0]   gnt_in1;
  logic [DATA_W-1:0]   gnt_in2;

  // Issue stage (p0): id of the pair currently on mul_in1/mul_in2.
  logic [ID_W-1:0]     iss_id_p0;

  // Tag pipe: entry k describes the operation issued k cycles ago, so entry
  // MUL_LAT lines up with the product on mul_out.
  logic [MUL_LAT:1]    tag_vld_pipe;
  logic [ID_W-1:0]     tag_id_pipe [1:MUL_LAT];

`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr;
`endif

  // ------------------------------------------------------------------------
  // Arbitration (combinational)
  // ------------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
`ifndef ARB_FIXED_PRIO_EN
    // Round robin as two ordered scans: first the indices at or above the
    // pointer, then wrap around to the ones below it.
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_vld[i] && (ID_W'(i) >= rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_vld[i]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end

    gnt_in1 = '0;
    gnt_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        gnt_in1 = req_in1[i*DATA_W +: DATA_W];
        gnt_in2 = req_in2[i*DATA_W +: DATA_W];
      end
    end
  end

  // Nothing is accepted while reset is asserted, so requesters never see a
  // handshake that the pipeline would drop.
  assign req_rdy = rstn ? (id_onehot(gnt_id) & {NREQ{gnt_any}}) : '0;

  // ------------------------------------------------------------------------
  // Stage p0: issue to the core, advance the arbitration pointer
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_vld   <= 1'b0;
      mul_in1   <= '0;
      mul_in2   <= '0;
      iss_id_p0 <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      mul_vld <= gnt_any;
      if (gnt_any) begin
        mul_in1   <= gnt_in1;
        mul_in2   <= gnt_in2;
        iss_id_p0 <= gnt_id;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr    <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stages p1..pMUL_LAT: tag pipe, shifts every cycle with no stall
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_pipe <= '0;
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_id_pipe[k] <= '0;
      end
    end else begin
      tag_vld_pipe[1] <= mul_vld;
      tag_id_pipe[1]  <= iss_id_p0;
      for (int k = 2; k <= MUL_LAT; k++) begin
        tag_vld_pipe[k] <= tag_vld_pipe[k-1];
        tag_id_pipe[k]  <= tag_id_pipe[k-1];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Return stage: capture the product for the tag that just matured
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_vld  <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (tag_vld_pipe[MUL_LAT]) begin
      rsp_vld  <= id_onehot(tag_id_pipe[MUL_LAT]);
      rsp_id   <= tag_id_pipe[MUL_LAT];
      rsp_data <= mul_out;
    end else begin
      rsp_vld  <= '0;
    end
  end

  assign busy = mul_vld | (|tag_vld_pipe) | (|rsp_vld);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Drives mul_share_arbiter with a registered-multiply core model. A monitor
// compares every cycle against a scoreboard model built from the
// arbitration and latency rules. Directed sequences cover single ops,
// alternation, back-to-back issue, full-width operands and reset mid-flight.
// Randomized traffic follows the directed sequences.
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int DW   = 1024;
  localparam int PW   = 2 * DW;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int IDW  = 1;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*DW-1:0]    req_in1;
  logic [NREQ*DW-1:0]    req_in2;
  logic                  mul_vld;
  logic [DW-1:0]         mul_in1;
  logic [DW-1:0]         mul_in2;
  logic [PW-1:0]         mul_out;
  logic [NREQ-1:0]       rsp_vld;
  logic [IDW-1:0]        rsp_id;
  logic [PW-1:0]         rsp_data;
  logic                  busy;

  mul_share_arbiter #(.DATA_W(DW), .NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .mul_vld  (mul_vld),
    .mul_in1  (mul_in1),
    .mul_in2  (mul_in2),
    .mul_out  (mul_out),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Core model: LAT-deep registered multiply.
  logic [PW-1:0] core_p [LAT];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) core_p[k] <= '0;
    end else begin
      core_p[0] <= PW'(mul_in1) * PW'(mul_in2);
      for (int k = 1; k < LAT; k++) core_p[k] <= core_p[k-1];
    end
  end
  assign mul_out = core_p[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits shown)", nm, act[63:0], exp[63:0]);
    end
  endtask

  // ------------------------------------------------------------------------
  // Scoreboard model: pending results with their due cycle
  // ------------------------------------------------------------------------
  typedef struct {
    int            due;
    int            id;
    logic [PW-1:0] prod;
  } rsp_t;

  rsp_t            q[$];
  int              cyc = 0;
  int              rr = 0;
  logic            m_mv = 1'b0;
  logic [DW-1:0]   m_in1 = '0;
  logic [DW-1:0]   m_in2 = '0;
  int              m_rid = 0;
  logic [PW-1:0]   m_rdata = '0;

  always @(negedge clk) begin
    int              g;
    int              start;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] erv;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    rsp_t            r;
    #2;
    cyc++;
    if (!rstn) begin
      chk("rst_req_rdy", PW'(req_rdy), '0);
      chk("rst_mul_vld", PW'(mul_vld), '0);
      chk("rst_mul_in1", PW'(mul_in1), '0);
      chk("rst_mul_in2", PW'(mul_in2), '0);
      chk("rst_rsp_vld", PW'(rsp_vld), '0);
      chk("rst_rsp_id", PW'(rsp_id), '0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_busy", PW'(busy), '0);
      q.delete();
      rr = 0; m_mv = 1'b0; m_in1 = '0; m_in2 = '0; m_rid = 0; m_rdata = '0;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = rr;
`endif
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_vld[(start + k) % NREQ]) g = (start + k) % NREQ;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("mon_req_rdy", PW'(req_rdy), PW'(er));
      chk("mon_mul_vld", PW'(mul_vld), PW'(m_mv));
      chk("mon_mul_in1", PW'(mul_in1), PW'(m_in1));
      chk("mon_mul_in2", PW'(mul_in2), PW'(m_in2));
      chk("mon_busy", PW'(busy), PW'(q.size() != 0));
      erv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        erv[r.id] = 1'b1;
        m_rid = r.id;
        m_rdata = r.prod;
      end
      chk("mon_rsp_vld", PW'(rsp_vld), PW'(erv));
      chk("mon_rsp_id", PW'(rsp_id), PW'(m_rid));
      chk("mon_rsp_data", rsp_data, m_rdata);
      if (g >= 0) begin
        a = req_in1[g*DW +: DW];
        b = req_in2[g*DW +: DW];
        r.due = cyc + LAT + 2;
        r.id = g;
        r.prod = PW'(a) * PW'(b);
        q.push_back(r);
        rr = (g + 1) % NREQ;
        m_mv = 1'b1;
        m_in1 = a;
        m_in2 = b;
      end else begin
        m_mv = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  typedef struct {
    int              id;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [PW-1:0]   prod;
    logic [NREQ-1:0] rv;
  } vec_t;

  vec_t            tbl[6];
  logic [PW-1:0]   big;
  logic [NREQ-1:0] acc;

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0:       v = DW'($urandom_range(0, 255));
      1:       v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    req_vld = '0;
    req_in1 = '0;
    req_in2 = '0;
    acc = '0;
    #1 rstn = 1'b0;

    big = '1;
    big = big - (PW'(1) << 1025) + PW'(2);
    tbl[0] = '{0, DW'(7), DW'(9), PW'(63), 2'b01};
    tbl[1] = '{1, DW'(4), DW'(5), PW'(20), 2'b10};
    tbl[2] = '{1, DW'(1), DW'(1), PW'(1), 2'b10};
    tbl[3] = '{0, '1, '1, big, 2'b01};
    tbl[4] = '{1, DW'(1) << 1023, DW'(2), PW'(1) << 1024, 2'b10};
    tbl[5] = '{0, DW'(0), DW'(12345), PW'(0), 2'b01};

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Isolated single operations from the table.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      req_vld = '0;
      req_vld[tbl[t].id] = 1'b1;
      req_in1[tbl[t].id*DW +: DW] = tbl[t].a;
      req_in2[tbl[t].id*DW +: DW] = tbl[t].b;
      #1 chk("t1_req_rdy", PW'(req_rdy), PW'(tbl[t].rv));
      @(negedge clk);
      req_vld = '0;
      #1;
      chk("t1_mul_vld", PW'(mul_vld), PW'(1'b1));
      chk("t1_mul_in1", PW'(mul_in1), PW'(tbl[t].a));
      chk("t1_busy", PW'(busy), PW'(1'b1));
      repeat (2) @(negedge clk);
      @(negedge clk);
      #1;
      chk("t1_rsp_vld", PW'(rsp_vld), PW'(tbl[t].rv));
      chk("t1_rsp_id", PW'(rsp_id), PW'(tbl[t].id));
      chk("t1_rsp_data", rsp_data, tbl[t].prod);
      @(negedge clk);
      #1;
      chk("t1_rsp_vld_off", PW'(rsp_vld), '0);
      chk("t1_busy_off", PW'(busy), '0);
      chk("t1_rsp_data_hold", rsp_data, tbl[t].prod);
    end

    // Both requesters continuously valid: grants and results alternate.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_vld = 2'b11;
      req_in1 = {DW'(4), DW'(2)};
      req_in2 = {DW'(5), DW'(3)};
      #1 chk("t2_req_rdy", PW'(req_rdy), (k % 2 == 0) ? PW'(2'b01) : PW'(2'b10));
      if (k >= 4) begin
        chk("t2_rsp_vld", PW'(rsp_vld), (k % 2 == 0) ? PW'(2'b01) : PW'(2'b10));
        chk("t2_rsp_data", rsp_data, (k % 2 == 0) ? PW'(6) : PW'(20));
      end
    end
    @(negedge clk);
    req_vld = '0;
    repeat (6) @(negedge clk);

    // Back-to-back from requester 1 only.
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      req_vld = 2'b10;
      req_in1[DW +: DW] = DW'(n);
      req_in2[DW +: DW] = DW'(n);
      #1 chk("t3_req_rdy", PW'(req_rdy), PW'(2'b10));
    end
    @(negedge clk);
    req_vld = '0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      #1;
      chk("t3_rsp_vld", PW'(rsp_vld), PW'(2'b10));
      chk("t3_rsp_data", rsp_data, PW'(n * n));
    end
    @(negedge clk);
    #1 chk("t3_rsp_vld_off", PW'(rsp_vld), '0);

    // Reset while three operations are in flight.
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      req_vld = 2'b01;
      req_in1[0 +: DW] = DW'(n + 10);
      req_in2[0 +: DW] = DW'(3);
      #1 chk("t5_req_rdy", PW'(req_rdy), PW'(2'b01));
    end
    @(negedge clk);
    req_vld = '0;
    rstn = 1'b0;
    #1;
    chk("t5_mul_vld_rst", PW'(mul_vld), '0);
    chk("t5_busy_rst", PW'(busy), '0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("t5_rsp_vld", PW'(rsp_vld), '0);
      chk("t5_rsp_data", rsp_data, '0);
      chk("t5_busy", PW'(busy), '0);
    end
    @(negedge clk);
    req_vld = 2'b11;
`ifdef ARB_FIXED_PRIO_EN
    #1 chk("t5_first_grant", PW'(req_rdy), PW'(2'b01));
`else
    #1 chk("t5_first_grant", PW'(req_rdy), PW'(2'b01));
`endif
    @(negedge clk);
    req_vld = '0;
    repeat (6) @(negedge clk);

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins every cycle while valid.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_vld = 2'b11;
      #1 chk("t6_req_rdy", PW'(req_rdy), PW'(2'b01));
    end
    @(negedge clk);
    req_vld = 2'b10;
    #1 chk("t6_req1_rdy", PW'(req_rdy), PW'(2'b10));
    @(negedge clk);
    req_vld = '0;
    repeat (6) @(negedge clk);
`endif

    // Randomized traffic; requesters hold operands until accepted.
    acc = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_vld[i] || acc[i]) begin
          req_vld[i] = ($urandom_range(0, 3) != 0);
          req_in1[i*DW +: DW] = rnd_op();
          req_in2[i*DW +: DW] = rnd_op();
        end
      end
      #1 acc = req_vld & req_rdy;
    end
    @(negedge clk);
    req_vld = '0;
    repeat (8) @(negedge clk);
    #1 chk("end_busy", PW'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
